// File: rtl/issue_queue.sv
// Age-ordered, self-compacting issue queue: priority select with oldest-first
// tie break, wakeup broadcast, branch-mask kill and a registered issue port.
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int WIDTH_BRM = 6,
  parameter int WIDTH_TAG = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_dis_en,
  input  logic [1:0]               i_pry,
  input  logic [6:0]               i_uop,
  input  logic [9:0]               i_func,
  input  logic [31:0]              i_imm,
  input  logic [WIDTH_TAG-1:0]     i_prd,
  input  logic [WIDTH_TAG-1:0]     i_prs1,
  input  logic [WIDTH_TAG-1:0]     i_prs2,
  input  logic                     i_rdy1,
  input  logic                     i_rdy2,
  input  logic [WIDTH_BRM-1:0]     i_brmask,
  input  logic [1:0]               i_wk_en,
  input  logic [WIDTH_TAG-1:0]     i_wk_tag0,
  input  logic [WIDTH_TAG-1:0]     i_wk_tag1,
  input  logic                     i_kill,
  input  logic [WIDTH_BRM-1:0]     i_kill_brmask,
  input  logic                     i_iss_stall,
  output logic                     o_ready,
  output logic                     o_iss_valid,
  output logic [6:0]               o_iss_uop,
  output logic [9:0]               o_iss_func,
  output logic [31:0]              o_iss_imm,
  output logic [WIDTH_TAG-1:0]     o_iss_prd,
  output logic [WIDTH_TAG-1:0]     o_iss_prs1,
  output logic [WIDTH_TAG-1:0]     o_iss_prs2,
  output logic [WIDTH_BRM-1:0]     o_iss_brmask,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [6:0]           uop;
    logic [9:0]           func;
    logic [31:0]          imm;
    logic [WIDTH_TAG-1:0] prd;
    logic [WIDTH_TAG-1:0] prs1;
    logic [WIDTH_TAG-1:0] prs2;
    logic [WIDTH_BRM-1:0] brmask;
  } iss_t;

  typedef struct packed {
    iss_t       p;
    logic [1:0] pry;
    logic       rdy1;
    logic       rdy2;
  } entry_t;

  entry_t         r_ent  [DEPTH];
  entry_t         w_next [DEPTH];
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_pos;
  iss_t           r_iss;
  logic           r_iss_valid;

  logic [DEPTH-1:0] w_kill_vec;
  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_keep;
  logic             w_sel_found;
  logic [IW-1:0]    w_sel_idx;
  logic [1:0]       w_best_pry;
  logic             w_do_iss;
  logic             w_dis_acc;
  entry_t           w_dis_ent;

  function automatic entry_t wake(input entry_t e, input logic [1:0] en,
                                  input logic [WIDTH_TAG-1:0] t0,
                                  input logic [WIDTH_TAG-1:0] t1);
    entry_t r;
    r = e;
    if ((en[0] && e.p.prs1 == t0) || (en[1] && e.p.prs1 == t1)) r.rdy1 = 1'b1;
    if ((en[0] && e.p.prs2 == t0) || (en[1] && e.p.prs2 == t1)) r.rdy2 = 1'b1;
    return r;
  endfunction

  assign o_ready = (r_count < CW'(DEPTH));

  // Kill and select. Strict '>' keeps the oldest slot among equal priorities.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_kill_vec  = '0;
    w_elig      = '0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_best_pry  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_vec[i] = i_kill && (r_ent[i].p.brmask > i_kill_brmask);
      w_elig[i]     = (CW'(i) < r_count) && r_ent[i].rdy1 && r_ent[i].rdy2 && !w_kill_vec[i];
      if (w_elig[i] && (!w_sel_found || r_ent[i].pry > w_best_pry)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(i);
        w_best_pry  = r_ent[i].pry;
      end
    end
    w_do_iss = w_sel_found && !i_iss_stall;
  end

  // Compaction of survivors, then append of the accepted dispatch at the tail.
  always_comb begin
    w_next = r_ent;
    w_keep = '0;
    w_pos  = '0;

    w_dis_ent.p.uop    = i_uop;
    w_dis_ent.p.func   = i_func;
    w_dis_ent.p.imm    = i_imm;
    w_dis_ent.p.prd    = i_prd;
    w_dis_ent.p.prs1   = i_prs1;
    w_dis_ent.p.prs2   = i_prs2;
    w_dis_ent.p.brmask = i_brmask;
    w_dis_ent.pry      = i_pry;
    w_dis_ent.rdy1     = i_rdy1 || (i_prs1 == '0);
    w_dis_ent.rdy2     = i_rdy2 || (i_prs2 == '0);

    w_dis_acc = i_dis_en && o_ready && !(i_kill && (i_brmask > i_kill_brmask));

    for (int i = 0; i < DEPTH; i++) begin
      w_keep[i] = (CW'(i) < r_count) && !w_kill_vec[i] && !(w_do_iss && (w_sel_idx == IW'(i)));
      if (w_keep[i]) begin
        w_next[w_pos[IW-1:0]] = wake(r_ent[i], i_wk_en, i_wk_tag0, i_wk_tag1);
        w_pos = w_pos + CW'(1);
      end
    end

    // Acceptance requires r_count < DEPTH, so the tail slot always exists here.
    if (w_dis_acc) begin
      w_next[w_pos[IW-1:0]] = wake(w_dis_ent, i_wk_en, i_wk_tag0, i_wk_tag1);
      w_pos = w_pos + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_iss_valid <= 1'b0;
      r_iss       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      r_count <= w_pos;
      if (w_do_iss) begin
        r_iss_valid <= 1'b1;
        r_iss       <= r_ent[w_sel_idx].p;
      end else if (!i_iss_stall) begin
        r_iss_valid <= 1'b0;
      end else if (i_kill && (r_iss.brmask > i_kill_brmask)) begin
        r_iss_valid <= 1'b0;
      end
    end
  end

  // NOTE: entry payload is left unreset; slots at or beyond r_count are never
  // observed, so clearing r_count alone discards every entry.
  always_ff @(posedge i_clk) begin
    r_ent <= w_next;
  end

  assign o_iss_valid  = r_iss_valid;
  assign o_iss_uop    = r_iss.uop;
  assign o_iss_func   = r_iss.func;
  assign o_iss_imm    = r_iss.imm;
  assign o_iss_prd    = r_iss.prd;
  assign o_iss_prs1   = r_iss.prs1;
  assign o_iss_prs2   = r_iss.prs2;
  assign o_iss_brmask = r_iss.brmask;
  assign o_count      = r_count;

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, 8, number of queue entries (power of two, >=2).
REQ-002 Parameter WIDTH_BRM, 6, branch-mask counter width, identical to decode stage.
REQ-003 Parameter WIDTH_TAG, 7, physical register tag width.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_dis_en  input  1  dispatch strobe (decode ctrl bit 0).
REQ-007 i_pry  input  2  dispatch priority (decode ctrl[4:3]).
REQ-008 i_uop  input  7  opcode; i_func input 10; i_imm input 32.
REQ-009 i_prd, i_prs1, i_prs2  input  WIDTH_TAG each  destination/source physical tags.
REQ-010 i_rdy1, i_rdy2  input  1 each  source operand already ready at dispatch.
REQ-011 i_brmask  input  WIDTH_BRM  branch depth of dispatched uop.
REQ-012 i_wk_en[1:0], i_wk_tag0, i_wk_tag1  input  2, WIDTH_TAG x2  wakeup broadcasts.
REQ-013 i_kill  input  1; i_kill_brmask  input  WIDTH_BRM  misprediction flush.
REQ-014 i_iss_stall  input  1  downstream cannot accept issued uop.
REQ-015 o_ready  output  1  queue can accept a dispatch this cycle.
REQ-016 o_iss_valid  output  1; o_iss_uop 7, o_iss_func 10, o_iss_imm 32, o_iss_prd/prs1/prs2 WIDTH_TAG, o_iss_brmask WIDTH_BRM  registered issue port.
REQ-017 o_count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 Entries SHALL be kept in age order, slot 0 oldest, compacted every cycle (no holes among valid slots).
REQ-019 o_ready SHALL equal (o_count < DEPTH), combinational from registered count; dispatch with o_ready=0 SHALL be ignored (no credit for same-cycle issue).
REQ-020 Accepted dispatch SHALL be written at the tail after compaction of issued/killed entries, visible for select the next cycle.
REQ-021 Source with tag 0 SHALL be marked ready at dispatch regardless of i_rdy1/i_rdy2.
REQ-022 Each enabled wakeup tag SHALL set rdy of every valid entry whose matching source tag equals it, including the entry dispatched in the same cycle.
REQ-023 An entry SHALL be eligible when valid, rdy1=1, rdy2=1, and not killed this cycle; wakeup takes effect for select one cycle later.
REQ-024 Select SHALL choose the eligible entry with highest pry; ties resolved by oldest slot.
REQ-025 When i_iss_stall=0 and an eligible entry exists, it SHALL be removed and its fields registered onto o_iss_* with o_iss_valid=1 next cycle (1-cycle latency).
REQ-026 When i_iss_stall=1, o_iss_* and o_iss_valid SHALL hold and no entry SHALL be removed.
REQ-027 When i_iss_stall=0 and nothing eligible, o_iss_valid SHALL be 0 next cycle.
REQ-028 On i_kill, entries with brmask > i_kill_brmask (unsigned) SHALL be invalidated; same-cycle dispatch with i_brmask > i_kill_brmask SHALL be dropped; killed entries SHALL never issue.
REQ-029 On i_kill, a registered o_iss_valid uop with o_iss_brmask > i_kill_brmask SHALL be cleared next cycle even if stalled.
REQ-030 Simultaneous issue, kill and dispatch SHALL be applied in order: kill, issue, compaction, append.
REQ-031 o_count SHALL reflect post-update occupancy and never exceed DEPTH.

Reset
REQ-032 On i_rst_n=0, asynchronously: all entries invalid, o_count=0, o_iss_valid=0, all o_iss_* fields 0, o_ready=1 after deassertion.
REQ-033 Reset asserted mid-operation SHALL discard all entries and pending issue without partial state.

Verification
REQ-034 Dispatch uop prs1=5,prs2=0,rdy1=0; wakeup tag 5 next cycle -> o_iss_valid=1 with that uop two cycles after wakeup.
REQ-035 Fill 8 ready-blocked entries -> o_count=8, o_ready=0; 9th dispatch ignored, count stays 8.
REQ-036 Three ready entries, pry 0,3,0 -> pry-3 entry issues first, then oldest pry-0, then remaining.
REQ-037 Entries brmask 1,2,3; i_kill with i_kill_brmask=1 -> only brmask-1 entry remains, o_count=1.
REQ-038 i_iss_stall=1 for 3 cycles with ready entries -> o_iss_* stable, o_count unchanged; release -> next entry issues.
REQ-039 Assert i_rst_n=0 with 4 valid entries and o_iss_valid=1 -> same cycle o_iss_valid=0, o_count=0.
